// File: rtl/aes_pkg.sv
// Shared AES datapath types: column width, byte/word types and the
// serializer state encoding.
package aes_pkg;

    localparam int Nb = 4;

    typedef logic [7:0] byte_t;
    typedef byte_t [Nb-1:0] word_t;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_e;

    localparam logic [1:0] LAST_IDX = 2'(Nb - 1);

    function automatic logic [1:0] idx_inc(input logic [1:0] idx);
        return idx + 2'd1;
    endfunction

endpackage

// File: rtl/mod_word_hold.sv
// Valid-flagged one-word holding register with load and clear.
// Used as the prefetch slot of mod_reg4_4to1.
module mod_word_hold
    import aes_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  load_i,
    input  logic  clear_i,
    input  word_t d_i,
    output logic  valid_o,
    output word_t q_o
);

    logic  valid_q, valid_d;
    word_t word_q, word_d;

    always_comb begin
        valid_d = valid_q;
        word_d  = word_q;
        if (load_i) begin
            valid_d = 1'b1;
            word_d  = d_i;
        end else if (clear_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            word_q  <= '0;
        end else begin
            valid_q <= valid_d;
            word_q  <= word_d;
        end
    end

    assign valid_o = valid_q;
    assign q_o     = word_q;

endmodule

// File: rtl/mod_reg4_4to1.sv
// Word-to-byte serializer, element 0 first. Define
// MOD_REG4_4TO1_PREFETCH_EN for a one-word prefetch slot (zero-bubble streaming).
module mod_reg4_4to1
    import aes_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  wr_en,
    input  word_t i,
    output logic  in_ready,
    output byte_t o,
    output logic  o_valid,
    output logic  o_last,
    input  logic  rd_en
);

    state_e     state_q, state_d;
    logic [1:0] idx_q, idx_d;
    word_t      sh_q, sh_d;
    byte_t      o_q, o_d;
    logic       ov_q, ov_d;
    logic       ol_q, ol_d;

    logic       wr_xfer;
    logic       rd_xfer;
    logic       done;
    logic       nxt_avail;
    word_t      nxt_word;
    logic       load_en;
    logic [1:0] idx_nxt;

    assign wr_xfer = wr_en && in_ready;
    assign rd_xfer = ov_q && rd_en;
    assign done    = (state_q == SHIFT) && rd_xfer && (idx_q == LAST_IDX);
    assign idx_nxt = idx_inc(idx_q);

`ifdef MOD_REG4_4TO1_PREFETCH_EN
    logic  hold_valid;
    word_t hold_q;
    logic  hold_load;
    logic  hold_clr;

    // Only words arriving mid-word are parked; at a word boundary
    // with an empty slot the input goes straight to the shifter.
    assign hold_load = wr_xfer && (state_q == SHIFT) && !done;
    assign hold_clr  = done && hold_valid;

    mod_word_hold u_hold (
        .clk     (clk),
        .reset   (reset),
        .load_i  (hold_load),
        .clear_i (hold_clr),
        .d_i     (i),
        .valid_o (hold_valid),
        .q_o     (hold_q)
    );

    assign in_ready  = !hold_valid;
    assign nxt_avail = hold_valid || wr_xfer;
    assign nxt_word  = hold_valid ? hold_q : i;
`else
    assign in_ready  = (state_q == IDLE);
    assign nxt_avail = wr_xfer;
    assign nxt_word  = i;
`endif

    assign load_en = ((state_q == IDLE) && wr_xfer) ||
                     (done && nxt_avail);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        sh_d    = sh_q;
        o_d     = o_q;
        ov_d    = ov_q;
        ol_d    = ol_q;
        if (load_en) begin
            state_d = SHIFT;
            idx_d   = 2'd0;
            sh_d    = nxt_word;
            o_d     = nxt_word[0];
            ov_d    = 1'b1;
            ol_d    = 1'b0;
        end else if (done) begin
            state_d = IDLE;
            idx_d   = 2'd0;
            ov_d    = 1'b0;
            ol_d    = 1'b0;
        end else if ((state_q == SHIFT) && rd_xfer) begin
            idx_d = idx_nxt;
            o_d   = sh_q[idx_nxt];
            ol_d  = (idx_nxt == LAST_IDX);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            sh_q    <= '0;
            o_q     <= 8'h00;
            ov_q    <= 1'b0;
            ol_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            sh_q    <= sh_d;
            o_q     <= o_d;
            ov_q    <= ov_d;
            ol_q    <= ol_d;
        end
    end

    assign o       = o_q;
    assign o_valid = ov_q;
    assign o_last  = ol_q;

endmodule

// File: tb/tb_mod_reg4_4to1.sv
// Scoreboard bench for mod_reg4_4to1; prefetch-specific cases are
// selected with MOD_REG4_4TO1_PREFETCH_EN.
module tb_mod_reg4_4to1;
    import aes_pkg::*;

    logic  clk;
    logic  reset;
    logic  wr_en;
    word_t i;
    logic  in_ready;
    byte_t o;
    logic  o_valid;
    logic  o_last;
    logic  rd_en;

    mod_reg4_4to1 dut (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .i        (i),
        .in_ready (in_ready),
        .o        (o),
        .o_valid  (o_valid),
        .o_last   (o_last),
        .rd_en    (rd_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    logic [31:0] tx_q[$];
    logic [8:0]  sb[$];

    int    cyc      = 0;
    int    nwx      = 0;
    int    nrx      = 0;
    int    wx_cyc   = 0;
    int    first_rx = -1;
    int    last_rx  = -1;
    bit    stall    = 1'b0;
    byte_t stall_o  = 8'h00;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic cycle(input bit we, input bit re);
        bit          wx, rx;
        logic [31:0] w;
        @(negedge clk);
        wr_en = we && (tx_q.size() > 0);
        w     = wr_en ? tx_q[0] : 32'h0;
        i     = w;
        rd_en = re;
        #1;
        wx = wr_en && in_ready;
        rx = o_valid && rd_en;
        if (stall && o_valid) chk("hold_o", {24'h0, o}, {24'h0, stall_o});
        stall   = o_valid && !rd_en;
        stall_o = o;
        if (rx) begin
            if (sb.size() == 0) chk("extra_byte", {23'h0, o_last, o}, 32'h0);
            else chk("byte", {23'h0, o_last, o}, {23'h0, sb.pop_front()});
            nrx++;
            if (first_rx < 0) first_rx = cyc;
            last_rx = cyc;
        end
        if (wx) begin
            for (int k = 0; k < Nb; k++)
                sb.push_back({k == Nb - 1, w[k*8 +: 8]});
            void'(tx_q.pop_front());
            nwx++;
            wx_cyc = cyc;
        end
        @(posedge clk);
        cyc++;
    endtask

    task automatic drain(input int pr, input int budget);
        int n = 0;
        while ((tx_q.size() > 0 || sb.size() > 0) && n < budget) begin
            cycle(1'b1, $urandom_range(99) < pr);
            n++;
        end
        if (tx_q.size() > 0 || sb.size() > 0)
            chk("drain_timeout", tx_q.size() + sb.size(), 0);
    endtask

    initial begin
        bit re_pat[7] = '{1, 0, 0, 1, 1, 0, 1};
        int nw0;
        reset = 1'b1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        i     = '0;
        #12;
        chk("rst_o", {24'h0, o}, 32'h0);
        chk("rst_valid", {31'h0, o_valid}, 32'h0);
        chk("rst_last", {31'h0, o_last}, 32'h0);
        chk("rst_ready", {31'h0, in_ready}, 32'h1);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);

        // single word, rd_en high
        first_rx = -1;
        tx_q.push_back(32'hA3A2A1A0);
        drain(100, 20);
        chk("latency", first_rx - wx_cyc, 1);
        chk("single_span", last_rx - first_rx, 3);
        cycle(1'b0, 1'b1);
        #1;
        chk("single_idle", {31'h0, o_valid}, 32'h0);

        // backpressure
        tx_q.push_back(32'hA3A2A1A0);
        cycle(1'b1, 1'b0);
        foreach (re_pat[k]) cycle(1'b0, re_pat[k]);
        drain(100, 20);

        // back-to-back
        first_rx = -1;
        tx_q.push_back(32'h11223344);
        tx_q.push_back(32'h55667788);
        drain(100, 40);
`ifdef MOD_REG4_4TO1_PREFETCH_EN
        chk("b2b_span", last_rx - first_rx, 7);
`else
        chk("b2b_span", last_rx - first_rx, 8);
`endif

`ifdef MOD_REG4_4TO1_PREFETCH_EN
        // overflow refusal
        nw0 = nwx;
        tx_q.push_back(32'h01020304);
        tx_q.push_back(32'h05060708);
        tx_q.push_back(32'h090A0B0C);
        for (int k = 0; k < 6; k++) cycle(1'b1, 1'b0);
        #1;
        chk("ovf_accepted", nwx - nw0, 2);
        chk("ovf_ready", {31'h0, in_ready}, 32'h0);
        chk("ovf_pending", tx_q.size(), 1);
        drain(100, 40);
`endif

        // mid-word reset
        tx_q.push_back(32'hDEADBEEF);
        cycle(1'b1, 1'b1);
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk("mrst_valid", {31'h0, o_valid}, 32'h0);
        chk("mrst_o", {24'h0, o}, 32'h0);
        chk("mrst_last", {31'h0, o_last}, 32'h0);
        chk("mrst_ready", {31'h0, in_ready}, 32'h1);
        sb.delete();
        tx_q.delete();
        stall = 1'b0;
        #1;
        reset = 1'b0;
        tx_q.push_back(32'hCAFEF00D);
        cycle(1'b1, 1'b0);
        #1;
        chk("restart_b0", {24'h0, o}, 32'h0D);
        drain(100, 20);

        // random soak
        nw0 = nwx;
        nrx = 0;
        for (int k = 0; k < 1000; k++) tx_q.push_back($urandom);
        while (tx_q.size() > 0 && cyc < 60000)
            cycle($urandom_range(99) < 70, $urandom_range(99) < 75);
        drain(100, 200);
        chk("soak_words", nwx - nw0, 1000);
        chk("soak_bytes", nrx, 4000);
        chk("sb_left", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
